// File: rtl/alu_ctrl_pipe_if.sv
// Decode-to-ALU handshake bundle for alu_ctrl_pipe.
// Carries the instruction, the pipeline controls and the registered ALU controls.
interface alu_ctrl_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [3:0]  alu_ctr;
  logic        alu_src_imm;
  logic [31:0] imm_ext;
  logic        illegal;
  logic        illegal_seen;

  modport master (
    output in_valid, instr, stall, flush,
    input  in_ready, out_valid, alu_ctr,
    input  alu_src_imm, imm_ext,
    input  illegal, illegal_seen
  );

  modport slave (
    input  in_valid, instr, stall, flush,
    output in_ready, out_valid, alu_ctr,
    output alu_src_imm, imm_ext,
    output illegal, illegal_seen
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// DLX ALU control decoder with one registered stage.
// Handles stall/flush and keeps a sticky illegal-instruction flag.
module alu_ctrl_pipe (
  input logic            clk,
  input logic            reset,
  alu_ctrl_pipe_if.slave bus
);

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        is_r;
  logic        is_i;
  logic        is_mem;
  logic        is_br;

  logic [3:0]  d_ctr;
  logic        d_imm;
  logic        d_zext;
  logic        d_ill;
  logic [31:0] d_ext;

  logic        v_q;
  logic [3:0]  ctr_q;
  logic        imm_q;
  logic [31:0] ext_q;
  logic        ill_q;
  logic        seen_q;

  assign opc = bus.instr[31:26];
  assign fn  = bus.instr[5:0];
  assign imm = bus.instr[15:0];

  assign is_r   = (opc == 6'h00);
  assign is_mem = (opc == 6'h23) || (opc == 6'h2B);
  assign is_br  = (opc == 6'h04) || (opc == 6'h05);
  assign is_i   = (opc inside {[6'h08:6'h0E],
                               [6'h18:6'h1D]});

  always_comb begin
    d_ctr  = 4'b0000;
    d_imm  = 1'b0;
    d_zext = 1'b0;
    d_ill  = 1'b0;
    unique case (1'b1)
      is_r: begin
        case (fn)
          6'h20: d_ctr = 4'b0000;
          6'h21: d_ctr = 4'b1000;
          6'h22: d_ctr = 4'b0001;
          6'h23: d_ctr = 4'b1001;
          6'h24: d_ctr = 4'b0010;
          6'h25: d_ctr = 4'b0110;
          6'h26: d_ctr = 4'b0100;
          6'h28: d_ctr = 4'b0101;
          6'h29: d_ctr = 4'b1101;
          6'h2A: d_ctr = 4'b0011;
          6'h2B: d_ctr = 4'b1011;
          6'h2C: d_ctr = 4'b0111;
          6'h2D: d_ctr = 4'b1111;
          default: d_ill = 1'b1;
        endcase
      end
      is_i: begin
        d_imm = 1'b1;
        case (opc)
          6'h08: d_ctr = 4'b0000;
          6'h09: d_ctr = 4'b1000;
          6'h0A: d_ctr = 4'b0001;
          6'h0B: d_ctr = 4'b1001;
          6'h0C: d_ctr = 4'b0010;
          6'h0D: d_ctr = 4'b0110;
          6'h0E: d_ctr = 4'b0100;
          6'h18: d_ctr = 4'b0101;
          6'h19: d_ctr = 4'b1101;
          6'h1A: d_ctr = 4'b0011;
          6'h1B: d_ctr = 4'b1011;
          6'h1C: d_ctr = 4'b0111;
          6'h1D: d_ctr = 4'b1111;
          default: d_ctr = 4'b0000;
        endcase
        // logical and unsigned-arith immediates are zero-extended
        d_zext = (opc inside {6'h09, 6'h0B,
                              6'h0C, 6'h0D,
                              6'h0E});
      end
      is_mem: d_imm = 1'b1;
      is_br:  d_ctr = 4'b0001;
      default: d_ill = 1'b1;
    endcase
  end

  always_comb begin
    d_ext = 32'h0;
    if (d_imm) begin
      if (d_zext) d_ext = {16'h0, imm};
      else        d_ext = {{16{imm[15]}}, imm};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      ctr_q  <= 4'b0000;
      imm_q  <= 1'b0;
      ext_q  <= 32'h0;
      ill_q  <= 1'b0;
      seen_q <= 1'b0;
    end else if (bus.flush) begin
      v_q <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        v_q   <= 1'b1;
        ctr_q <= d_ctr;
        imm_q <= d_imm;
        ext_q <= d_ext;
        ill_q <= d_ill;
        if (d_ill) seen_q <= 1'b1;
      end else begin
        v_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = ~bus.stall;
  assign bus.out_valid    = v_q;
  assign bus.alu_ctr      = ctr_q;
  assign bus.alu_src_imm  = imm_q;
  assign bus.imm_ext      = ext_q;
  assign bus.illegal      = ill_q;
  assign bus.illegal_seen = seen_q;

endmodule
